mario_motion_ctrl: RTL and testbench
====================================

MARIO_MOTION_CTRL -- requirements
Module: mario_motion_ctrl

Interface
REQ-001 Parameter X_INIT, 32: x position after reset or soft reset.
REQ-002 Parameter X_MAX, 624: upper x bound (inclusive); lower x bound is fixed at 0.
REQ-003 Parameter Y_GROUND, 400: ground y, and y after reset; screen y grows downward.
REQ-004 Parameter STEP_X, 2: x pixels moved per frame.
REQ-005 Parameter JUMP_V, 12: initial upward speed at jump start.
REQ-006 Parameter GRAV, 1: speed change per frame.
REQ-007 Parameter VMAX, 15: fall speed cap.
REQ-008 clk  in  1  system clock.
REQ-009 reset_n  in  1  reset, asynchronous, active-low.
REQ-010 frame_tick  in  1  one-cycle pulse per video frame, synchronous to clk.
REQ-011 avs_address  in  2  word address: 0 CMD, 1 CTRL, 2 STATUS.
REQ-012 avs_write / avs_read  in  1 each  Avalon-MM strobes; no waitrequest.
REQ-013 avs_writedata  in  32  write data.
REQ-014 avs_readdata  out  32  registered read data.
REQ-015 position  out  32  {y[15:0], x[15:0]}; drives the position PIO in_port.
REQ-016 busy  out  1  high while an update sequence runs.

Function
REQ-017 CMD register: bit0 LEFT, bit1 RIGHT, bit2 JUMP (held-key levels); writable and readable; reset 0.
REQ-018 CTRL register: bit0 ENABLE (reset 0); bit1 SOFT_RST is write-1, self-clearing, and reads 0.
REQ-019 STATUS register (read-only):
- [15:0] frame counter: increments on each accepted tick, wraps.
- [23:16] overrun count: saturates at 255.
- [25:24] motion state: GROUND=0, RISE=1, FALL=2.
- [26] busy.
REQ-020 Read latency is one cycle: avs_readdata is updated on the edge after avs_read; reads of address 3 return 0; writes to addresses 2 and 3 are ignored.
REQ-021 Sequencer FSM states: IDLE, CALC_X, CALC_Y, COMMIT.
- IDLE -> CALC_X on frame_tick with ENABLE=1: CMD is sampled and busy is asserted.
- CALC_X -> CALC_Y -> COMMIT -> IDLE, one cycle each.
REQ-022 position, motion state and vy update only in COMMIT, atomically, exactly 3 cycles after the accepted tick edge; position is otherwise stable.
REQ-023 frame_tick arriving while busy=1 is ignored and increments the overrun count; frame_tick with ENABLE=0 is ignored and is not counted.
REQ-024 A CMD write in the same cycle as an accepted tick does not affect that frame; the frame uses the old CMD value.
REQ-025 x rule (16-bit unsigned, no wrap):
- LEFT only: x = max(x-STEP_X, 0).
- RIGHT only: x = min(x+STEP_X, X_MAX).
- Both or neither: x unchanged.
REQ-026 JUMP is edge-qualified: a jump starts only when the sampled JUMP=1, the previous accepted frame's JUMP=0, and state=GROUND.
REQ-027 Jump start (GROUND): vy=JUMP_V and state=RISE, with the first rise step applied in the same frame.
REQ-028 RISE step: y = max(y-vy, 0), then vy = vy-GRAV; when vy reaches 0, state=FALL.
REQ-029 FALL step: vy = min(vy+GRAV, VMAX); if y+vy >= Y_GROUND then y=Y_GROUND, vy=0, state=GROUND; else y = y+vy.
REQ-030 vy is an 8-bit unsigned magnitude; the y sums use 17-bit intermediates.
REQ-031 SOFT_RST written while busy aborts the sequence with no COMMIT.
- Next cycle: x=X_INIT, y=Y_GROUND, vy=0, state=GROUND, sequencer IDLE.
- Counters are not cleared.

Reset
REQ-032 Asynchronous assertion of reset_n sets:
- position={Y_GROUND, X_INIT} (0x0190_0020 at defaults).
- avs_readdata=0, all registers 0, vy=0, motion state GROUND, sequencer IDLE, busy=0.
REQ-033 Reset asserted mid-sequence discards the pending update; no partial position is ever visible.

Verification
REQ-034 Reset: after release, position=0x0190_0020 and busy=0; a STATUS read returns 0.
REQ-035 Move right: ENABLE=1, CMD=0x2, 3 ticks -> x=38.
- position changes exactly 3 cycles after each tick.
- STATUS[15:0]=3.
REQ-036 Clamp left and right:
- CMD=0x1, 16 ticks -> x=0; 17th tick -> x stays 0.
- With x=624 and CMD=0x2, a tick -> x stays 624.
- CMD=0x3 -> x unchanged.
REQ-037 Jump arc: CMD=0x4 then 24 ticks.
- After tick 1: y=388.
- After tick 12: y=322, state FALL.
- After tick 24: y=400, state GROUND.
- Holding JUMP through the 24 ticks does not trigger a second jump.
REQ-038 Overrun: a second tick 1 cycle after an accepted tick -> overrun count=1 and the frame counter increments by only 1.
REQ-039 Soft reset: with x=40 and busy=1, write CTRL=0x3 -> no commit; position=0x0190_0020 and ENABLE stays 1.

Source files
------------

// File: rtl/mario_motion_ctrl.sv
// Frame-driven sprite motion sequencer behind an Avalon-MM register slave.
// The position commits 3 cycles after an accepted frame_tick; ticks that arrive while busy are counted as overruns.
module mario_motion_ctrl #(
  parameter int X_INIT   = 32,
  parameter int X_MAX    = 624,
  parameter int Y_GROUND = 400,
  parameter int STEP_X   = 2,
  parameter int JUMP_V   = 12,
  parameter int GRAV     = 1,
  parameter int VMAX     = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_tick,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic        avs_read,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic [31:0] position,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC_X, S_CALC_Y, S_COMMIT} seq_t;
  typedef enum logic [1:0] {M_GROUND = 2'd0, M_RISE = 2'd1, M_FALL = 2'd2} mstate_t;

  localparam logic [15:0] X_INIT_W   = 16'(X_INIT);
  localparam logic [16:0] X_MAX_W    = 17'(X_MAX);
  localparam logic [15:0] Y_GROUND_W = 16'(Y_GROUND);
  localparam logic [16:0] Y_GND_17   = 17'(Y_GROUND);
  localparam logic [15:0] STEP_W     = 16'(STEP_X);
  localparam logic [7:0]  JUMP_V_W   = 8'(JUMP_V);
  localparam logic [7:0]  GRAV_W     = 8'(GRAV);
  localparam logic [8:0]  VMAX_W     = 9'(VMAX);

  seq_t        seq, seq_nxt;
  mstate_t     mstate, nms_c, nms_r, ms_eff;
  logic [2:0]  cmd, cmd_s;
  logic        enable, prev_jump;
  logic [15:0] frame_cnt;
  logic [7:0]  ovr_cnt;
  logic [15:0] x, y, nx_c, nx_r, ny_c, ny_r;
  logic [7:0]  vy, nvy_c, nvy_r, vy_eff, vfall;
  logic [16:0] x_sum, y_sum;
  logic [8:0]  v_sum;
  logic        wr_cmd, wr_ctrl, soft_rst, accept, overrun, jump_go;

  assign wr_cmd   = avs_write && (avs_address == 2'd0);
  assign wr_ctrl  = avs_write && (avs_address == 2'd1);
  assign soft_rst = wr_ctrl && avs_writedata[1];
  assign busy     = (seq != S_IDLE);
  assign accept   = frame_tick && enable && !busy && !soft_rst;
  assign overrun  = frame_tick && enable && busy;
  assign position = {y, x};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) seq <= S_IDLE;
    else          seq <= seq_nxt;
  end

  always_comb begin
    seq_nxt = seq;
    case (seq)
      S_IDLE:   if (accept) seq_nxt = S_CALC_X;
      S_CALC_X: seq_nxt = S_CALC_Y;
      S_CALC_Y: seq_nxt = S_COMMIT;
      S_COMMIT: seq_nxt = S_IDLE;
      default:  seq_nxt = S_IDLE;
    endcase
    if (soft_rst) seq_nxt = S_IDLE;
  end

  // Horizontal step with saturation at both screen edges.
  always_comb begin
    x_sum = {1'b0, x} + {1'b0, STEP_W};
    nx_c  = x;
    case (cmd_s[1:0])
      2'b01:   nx_c = (x < STEP_W) ? 16'd0 : x - STEP_W;
      2'b10:   nx_c = (x_sum > X_MAX_W) ? X_MAX_W[15:0] : x_sum[15:0];
      default: nx_c = x;
    endcase
  end

  // A fresh jump press on the ground enters RISE and takes its first step this frame.
  always_comb begin
    jump_go = cmd_s[2] && !prev_jump && (mstate == M_GROUND);
    vy_eff  = jump_go ? JUMP_V_W : vy;
    ms_eff  = jump_go ? M_RISE : mstate;
    v_sum   = {1'b0, vy} + {1'b0, GRAV_W};
    vfall   = (v_sum > VMAX_W) ? VMAX_W[7:0] : v_sum[7:0];
    y_sum   = {1'b0, y} + {9'd0, vfall};
    ny_c    = y;
    nvy_c   = vy;
    nms_c   = mstate;
    case (ms_eff)
      M_RISE: begin
        ny_c  = (y < {8'd0, vy_eff}) ? 16'd0 : y - {8'd0, vy_eff};
        nvy_c = (vy_eff <= GRAV_W) ? 8'd0 : vy_eff - GRAV_W;
        nms_c = (nvy_c == 8'd0) ? M_FALL : M_RISE;
      end
      M_FALL: begin
        if (y_sum >= Y_GND_17) begin
          ny_c  = Y_GROUND_W;
          nvy_c = 8'd0;
          nms_c = M_GROUND;
        end else begin
          ny_c  = y_sum[15:0];
          nvy_c = vfall;
          nms_c = M_FALL;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd       <= 3'd0;
      cmd_s     <= 3'd0;
      enable    <= 1'b0;
      prev_jump <= 1'b0;
      frame_cnt <= 16'd0;
      ovr_cnt   <= 8'd0;
      nx_r      <= 16'd0;
      ny_r      <= 16'd0;
      nvy_r     <= 8'd0;
      nms_r     <= M_GROUND;
      x         <= X_INIT_W;
      y         <= Y_GROUND_W;
      vy        <= 8'd0;
      mstate    <= M_GROUND;
    end else begin
      if (wr_cmd)  cmd    <= avs_writedata[2:0];
      if (wr_ctrl) enable <= avs_writedata[0];
      if (accept) begin
        cmd_s     <= cmd;
        frame_cnt <= frame_cnt + 16'd1;
      end
      if (overrun && ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
      if (seq == S_CALC_X) nx_r <= nx_c;
      if (seq == S_CALC_Y) begin
        ny_r  <= ny_c;
        nvy_r <= nvy_c;
        nms_r <= nms_c;
      end
      if (soft_rst) begin
        x      <= X_INIT_W;
        y      <= Y_GROUND_W;
        vy     <= 8'd0;
        mstate <= M_GROUND;
      end else if (seq == S_COMMIT) begin
        x         <= nx_r;
        y         <= ny_r;
        vy        <= nvy_r;
        mstate    <= nms_r;
        prev_jump <= cmd_s[2];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avs_readdata <= 32'd0;
    end else if (avs_read) begin
      case (avs_address)
        2'd0:    avs_readdata <= {29'd0, cmd};
        2'd1:    avs_readdata <= {31'd0, enable};
        2'd2:    avs_readdata <= {5'd0, busy, mstate, ovr_cnt, frame_cnt};
        default: avs_readdata <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mario_motion_ctrl.sv
// Directed bench for mario_motion_ctrl: register access, movement clamps, jump arc, overrun, soft reset.
module tb_mario_motion_ctrl;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        frame_tick = 1'b0;
  logic [1:0]  avs_address = 2'd0;
  logic        avs_write = 1'b0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_writedata = 32'd0;
  logic [31:0] avs_readdata;
  logic [31:0] position;
  logic        busy;

  int checks = 0;
  int failures = 0;
  logic [31:0] rdat, st0;

  mario_motion_ctrl dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .avs_address(avs_address), .avs_write(avs_write), .avs_read(avs_read),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
    .position(position), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic frame();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("reset_pos", position, 32'h0190_0020);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    rd(2'd2, rdat); chk("reset_status", rdat, 32'd0);
    rd(2'd0, rdat); chk("reset_cmd", rdat, 32'd0);

    // Move right with cycle-accurate commit timing.
    wr(2'd1, 32'h1);
    wr(2'd0, 32'h2);
    rd(2'd0, rdat); chk("cmd_readback", rdat, 32'h2);
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    chk("busy_after_tick", {31'd0, busy}, 32'd1);
    @(negedge clk);
    @(negedge clk); chk("pos_before_commit", position, 32'h0190_0020);
    @(negedge clk); chk("pos_at_commit", position, 32'h0190_0022);
    chk("busy_after_commit", {31'd0, busy}, 32'd0);
    frame(); frame();
    chk("right_x38", position, 32'h0190_0026);
    rd(2'd2, rdat); chk("frame_cnt3", {16'd0, rdat[15:0]}, 32'd3);

    // Left clamp from X_INIT.
    wr(2'd1, 32'h3);
    rd(2'd1, rdat); chk("ctrl_softrst_reads0", rdat, 32'h1);
    chk("softrst_idle_pos", position, 32'h0190_0020);
    wr(2'd0, 32'h1);
    for (int i = 0; i < 16; i++) frame();
    chk("left_x0", position, 32'h0190_0000);
    frame();
    chk("left_clamp0", position, 32'h0190_0000);

    // Right clamp at X_MAX, then both keys held.
    wr(2'd0, 32'h2);
    for (int i = 0; i < 312; i++) frame();
    chk("right_x624", position, 32'h0190_0270);
    frame();
    chk("right_clamp624", position, 32'h0190_0270);
    wr(2'd0, 32'h3);
    frame();
    chk("both_keys", position, 32'h0190_0270);

    // Jump arc from ground with JUMP held throughout.
    wr(2'd1, 32'h3);
    wr(2'd0, 32'h4);
    frame();
    chk("jump_t1_pos", position, {16'd388, 16'd32});
    rd(2'd2, rdat); chk("jump_t1_state", {30'd0, rdat[25:24]}, 32'd1);
    for (int i = 2; i <= 12; i++) frame();
    chk("jump_t12_pos", position, {16'd322, 16'd32});
    rd(2'd2, rdat); chk("jump_t12_state", {30'd0, rdat[25:24]}, 32'd2);
    frame();
    chk("jump_t13_pos", position, {16'd323, 16'd32});
    for (int i = 14; i <= 24; i++) frame();
    chk("jump_t24_pos", position, {16'd400, 16'd32});
    rd(2'd2, rdat); chk("jump_t24_state", {30'd0, rdat[25:24]}, 32'd0);
    frame();
    chk("no_rejump", position, {16'd400, 16'd32});

    // Overrun: second tick one cycle after an accepted one.
    wr(2'd0, 32'h0);
    rd(2'd2, st0);
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    repeat (4) @(negedge clk);
    rd(2'd2, rdat);
    chk("overrun_cnt", {24'd0, rdat[23:16]}, 32'd1);
    chk("overrun_frames", {16'd0, rdat[15:0]}, {16'd0, st0[15:0] + 16'd1});

    // Disabled ticks neither advance nor count.
    wr(2'd1, 32'h0);
    wr(2'd0, 32'h2);
    frame();
    chk("disabled_pos", position, {16'd400, 16'd32});
    rd(2'd2, rdat);
    chk("disabled_status", {8'd0, rdat[23:0]}, {8'd0, 8'd1, st0[15:0] + 16'd1});

    // Soft reset mid-sequence at x=40.
    wr(2'd1, 32'h1);
    for (int i = 0; i < 4; i++) frame();
    chk("pre_softrst_x40", position, {16'd400, 16'd40});
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    avs_address = 2'd1; avs_writedata = 32'h3; avs_write = 1'b1;
    @(negedge clk); avs_write = 1'b0;
    chk("softrst_busy", {31'd0, busy}, 32'd0);
    chk("softrst_pos", position, 32'h0190_0020);
    repeat (4) @(negedge clk);
    chk("softrst_no_commit", position, 32'h0190_0020);
    rd(2'd1, rdat); chk("softrst_enable", rdat, 32'h1);

    // Unmapped address and read-only STATUS.
    rd(2'd3, rdat); chk("addr3_zero", rdat, 32'd0);
    rd(2'd2, st0);
    wr(2'd2, 32'hFFFF_FFFF);
    rd(2'd2, rdat); chk("status_ro", rdat, st0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
